multicycle_sequencer: RTL and testbench

//   Main state sequencer of the multicycle non-pipelined CPU54 core.
//   - Steps each instruction through IF/ID/EX/MEM/WB, plus MDU-wait and trap-entry states.
//   - Emits per-state strobes that gate the instruction decoder's control outputs.
//   - Handles the memory and MDU completion handshakes.
//   - Counts retired instructions.

---
 rtl/multicycle_sequencer.sv | 174 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Main state sequencer of the multicycle CPU54 core.
// Steps each instruction through IF/ID/EX/MEM/WB plus MDU-wait and trap entry,
// drives the per-state strobes and counts retired instructions.
// Optional feature: define MDU_TIMEOUT_EN to build the MDU watchdog that traps
// after MDU_TIMEOUT cycles in S_MDU without mdu_done.
module multicycle_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_mdu,
    input  logic             is_wb,
    input  logic             is_trap,
    input  logic             mem_ready,
    input  logic             mdu_done,
    output logic [2:0]       state,
    output logic [4:0]       beat,
    output logic             mem_req,
    output logic             IR_in,
    output logic             PC_in,
    output logic             mdu_start,
    output logic             rf_we_en,
    output logic             exc_entry,
    output logic             instr_done,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_MDU  = 3'd5,
        S_TRAP = 3'd6
    } state_t;

    state_t cur, nxt;
    logic   to_hit;

`ifdef MDU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);
    logic [7:0] to_cnt;

    // Watchdog counter: zero outside S_MDU, so it starts at 0 on every entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_cnt <= 8'd0;
        else if (cur != S_MDU)
            to_cnt <= 8'd0;
        else
            to_cnt <= to_cnt + 8'd1;
    end

    assign to_hit = (to_cnt == TO_LAST);
`else
    // Without the watchdog S_MDU waits forever; keep the parameter referenced
    logic unused_cfg;
    assign unused_cfg = ^(8'(MDU_TIMEOUT));
    assign to_hit     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur <= S_IF;
        else
            cur <= nxt;
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instret <= '0;
        else if (instr_done)
            instret <= instret + CNT_W'(1);
    end

    // Next-state and strobe decode; strobes are suppressed while reset is held
    always_comb begin
        nxt        = cur;
        beat       = 5'b00000;
        mem_req    = 1'b0;
        IR_in      = 1'b0;
        PC_in      = 1'b0;
        mdu_start  = 1'b0;
        rf_we_en   = 1'b0;
        exc_entry  = 1'b0;
        instr_done = 1'b0;
        timeout    = 1'b0;
        case (cur)
            S_IF:  beat = 5'b00001;
            S_ID:  beat = 5'b00010;
            S_EX:  beat = 5'b00100;
            S_MEM: beat = 5'b01000;
            S_WB:  beat = 5'b10000;
            default: beat = 5'b00000;
        endcase
        if (reset) begin
            case (cur)
                S_IF: begin
                    mem_req = run;
                    if (run && mem_ready) begin
                        IR_in = 1'b1;
                        nxt   = S_ID;
                    end
                end
                S_ID: begin
                    nxt = is_trap ? S_TRAP : S_EX;
                end
                S_EX: begin
                    if (is_mdu) begin
                        mdu_start = 1'b1;
                        nxt       = S_MDU;
                    end else if (is_load || is_store) begin
                        nxt = S_MEM;
                    end else if (is_wb) begin
                        nxt = S_WB;
                    end else begin
                        PC_in      = 1'b1;
                        instr_done = 1'b1;
                        nxt        = S_IF;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        if (is_load) begin
                            nxt = S_WB;
                        end else begin
                            PC_in      = 1'b1;
                            instr_done = 1'b1;
                            nxt        = S_IF;
                        end
                    end
                end
                S_WB: begin
                    rf_we_en   = 1'b1;
                    PC_in      = 1'b1;
                    instr_done = 1'b1;
                    nxt        = S_IF;
                end
                S_MDU: begin
                    if (mdu_done) begin
                        if (is_wb) begin
                            nxt = S_WB;
                        end else begin
                            PC_in      = 1'b1;
                            instr_done = 1'b1;
                            nxt        = S_IF;
                        end
                    end else if (to_hit) begin
                        timeout = 1'b1;
                        nxt     = S_TRAP;
                    end
                end
                S_TRAP: begin
                    exc_entry = 1'b1;
                    PC_in     = 1'b1;
                    nxt       = S_IF;
                end
                default: nxt = S_IF;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the stimulus process drives one
// cycle of inputs and queues the hand-computed outputs for that cycle; the
// monitor pops and compares on the falling edge.
module tb_multicycle_sequencer;

    localparam int CNT_W = 3;

    // decode word {is_load, is_store, is_mdu, is_wb, is_trap}
    localparam logic [4:0] D_NOP  = 5'b00000;
    localparam logic [4:0] D_ADDU = 5'b00010;
    localparam logic [4:0] D_LW   = 5'b10010;
    localparam logic [4:0] D_SW   = 5'b01000;
    localparam logic [4:0] D_DIV  = 5'b00100;
    localparam logic [4:0] D_MIX  = 5'b10110;
    localparam logic [4:0] D_SYS  = 5'b00001;

    // strobe word {mem_req, IR_in, PC_in, mdu_start, rf_we_en, exc_entry, instr_done, timeout}
    localparam logic [7:0] Z    = 8'b0000_0000;
    localparam logic [7:0] FET  = 8'b1100_0000;
    localparam logic [7:0] REQ  = 8'b1000_0000;
    localparam logic [7:0] WBK  = 8'b0010_1010;
    localparam logic [7:0] RET  = 8'b0010_0010;
    localparam logic [7:0] STR  = 8'b1010_0010;
    localparam logic [7:0] MST  = 8'b0001_0000;
    localparam logic [7:0] TRP  = 8'b0010_0100;
    localparam logic [7:0] TMO  = 8'b0000_0001;

    logic clk = 1'b0;
    logic reset, run, is_load, is_store, is_mdu, is_wb, is_trap, mem_ready, mdu_done;
    logic [2:0] state;
    logic [4:0] beat;
    logic mem_req, IR_in, PC_in, mdu_start, rf_we_en, exc_entry, instr_done, timeout;
    logic [CNT_W-1:0] instret;

    typedef struct {
        int               id;
        logic [2:0]       st;
        logic [4:0]       bt;
        logic [7:0]       sb;
        logic [CNT_W-1:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_push = 0;

    multicycle_sequencer #(.CNT_W(CNT_W), .MDU_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .run(run),
        .is_load(is_load), .is_store(is_store), .is_mdu(is_mdu),
        .is_wb(is_wb), .is_trap(is_trap),
        .mem_ready(mem_ready), .mdu_done(mdu_done),
        .state(state), .beat(beat), .mem_req(mem_req), .IR_in(IR_in),
        .PC_in(PC_in), .mdu_start(mdu_start), .rf_we_en(rf_we_en),
        .exc_entry(exc_entry), .instr_done(instr_done), .timeout(timeout),
        .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] beat_of(input logic [2:0] s);
        case (s)
            3'd0: return 5'b00001;
            3'd1: return 5'b00010;
            3'd2: return 5'b00100;
            3'd3: return 5'b01000;
            3'd4: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // one clock of stimulus plus the outputs expected during that clock
    task automatic cyc(input logic r, input logic rn, input logic [4:0] dec,
                       input logic mr, input logic md,
                       input logic [2:0] est, input logic [7:0] esb,
                       input logic [CNT_W-1:0] eir);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; run = rn;
        {is_load, is_store, is_mdu, is_wb, is_trap} = dec;
        mem_ready = mr; mdu_done = md;
        e.id = n_push; e.st = est; e.bt = beat_of(est); e.sb = esb; e.ir = eir;
        exp_q.push_back(e);
        n_push++;
    endtask

    // monitor: compare queued expectations against the DUT mid-cycle
    initial begin
        exp_t e;
        logic [7:0] sb;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                sb = {mem_req, IR_in, PC_in, mdu_start, rf_we_en, exc_entry, instr_done, timeout};
                n_vec++;
                if (state !== e.st || beat !== e.bt || sb !== e.sb || instret !== e.ir) begin
                    n_bad++;
                    $display("FAIL vec%0d: got state=%0d beat=%b strobes=%b instret=%0d, want state=%0d beat=%b strobes=%b instret=%0d",
                             e.id, state, beat, sb, instret, e.st, e.bt, e.sb, e.ir);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; run = 1'b0;
        {is_load, is_store, is_mdu, is_wb, is_trap} = 5'b0;
        mem_ready = 1'b0; mdu_done = 1'b0;

        // reset state, then idle with run low
        cyc(0, 1, D_NOP, 1, 0, 0, Z, 0);
        cyc(1, 0, D_NOP, 1, 0, 0, Z, 0);
        // ADDU
        cyc(1, 1, D_ADDU, 1, 0, 0, FET, 0);
        cyc(1, 1, D_ADDU, 1, 0, 1, Z, 0);
        cyc(1, 1, D_ADDU, 1, 0, 2, Z, 0);
        cyc(1, 1, D_ADDU, 1, 0, 4, WBK, 0);
        // LW with two wait cycles
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 1);
        cyc(1, 1, D_LW, 1, 0, 1, Z, 1);
        cyc(1, 1, D_LW, 0, 0, 2, Z, 1);
        cyc(1, 1, D_LW, 0, 0, 3, REQ, 1);
        cyc(1, 1, D_LW, 0, 0, 3, REQ, 1);
        cyc(1, 1, D_LW, 1, 0, 3, REQ, 1);
        cyc(1, 1, D_LW, 1, 0, 4, WBK, 1);
        // SW
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 2);
        cyc(1, 1, D_SW, 1, 0, 1, Z, 2);
        cyc(1, 1, D_SW, 1, 0, 2, Z, 2);
        cyc(1, 1, D_SW, 1, 0, 3, STR, 2);
        // DIV, mdu_done during EX is ignored, completes on 10th MDU cycle
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 3);
        cyc(1, 1, D_DIV, 1, 0, 1, Z, 3);
        cyc(1, 1, D_DIV, 1, 1, 2, MST, 3);
        for (int i = 0; i < 9; i++) cyc(1, 1, D_DIV, 1, 0, 5, Z, 3);
        cyc(1, 1, D_DIV, 1, 1, 5, RET, 3);
        // SYSCALL does not retire
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 4);
        cyc(1, 1, D_SYS, 1, 0, 1, Z, 4);
        cyc(1, 1, D_SYS, 1, 0, 6, TRP, 4);
        cyc(1, 1, D_NOP, 0, 0, 0, REQ, 4);
        // is_mdu beats is_load; MDU completion with is_wb goes through WB
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 4);
        cyc(1, 1, D_MIX, 1, 0, 1, Z, 4);
        cyc(1, 1, D_MIX, 1, 0, 2, MST, 4);
        cyc(1, 1, D_MIX, 1, 1, 5, Z, 4);
        cyc(1, 1, D_MIX, 1, 0, 4, WBK, 4);
        // run drops mid-instruction: finishes, then holds in IF
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 5);
        cyc(1, 0, D_NOP, 1, 0, 1, Z, 5);
        cyc(1, 0, D_NOP, 1, 0, 2, RET, 5);
        cyc(1, 0, D_NOP, 1, 0, 0, Z, 6);
        cyc(1, 0, D_NOP, 1, 0, 0, Z, 6);
        // two more retires wrap the 3-bit counter 7 -> 0
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 6);
        cyc(1, 1, D_NOP, 1, 0, 1, Z, 6);
        cyc(1, 1, D_NOP, 1, 0, 2, RET, 6);
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 7);
        cyc(1, 1, D_NOP, 1, 0, 1, Z, 7);
        cyc(1, 1, D_NOP, 1, 0, 2, RET, 7);
        cyc(1, 0, D_NOP, 1, 0, 0, Z, 0);
        // one LW so instret is nonzero, then reset while in MEM
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 0);
        cyc(1, 1, D_LW, 1, 0, 1, Z, 0);
        cyc(1, 1, D_LW, 1, 0, 2, Z, 0);
        cyc(1, 1, D_LW, 1, 0, 3, REQ, 0);
        cyc(1, 1, D_LW, 1, 0, 4, WBK, 0);
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 1);
        cyc(1, 1, D_LW, 0, 0, 1, Z, 1);
        cyc(1, 1, D_LW, 0, 0, 2, Z, 1);
        cyc(1, 1, D_LW, 0, 0, 3, REQ, 1);
        cyc(0, 1, D_LW, 0, 0, 0, Z, 0);
        cyc(1, 1, D_NOP, 0, 0, 0, REQ, 0);
        cyc(1, 0, D_NOP, 0, 0, 0, Z, 0);
`ifdef MDU_TIMEOUT_EN
        // MDU never answers: timeout on the 64th MDU cycle, then TRAP
        cyc(1, 1, D_NOP, 1, 0, 0, FET, 0);
        cyc(1, 1, D_ADDU | D_DIV, 1, 0, 1, Z, 0);
        cyc(1, 1, D_ADDU | D_DIV, 1, 0, 2, MST, 0);
        for (int i = 0; i < 63; i++) cyc(1, 1, D_ADDU | D_DIV, 1, 0, 5, Z, 0);
        cyc(1, 1, D_ADDU | D_DIV, 1, 0, 5, TMO, 0);
        cyc(1, 0, D_ADDU | D_DIV, 1, 0, 6, TRP, 0);
        cyc(1, 0, D_NOP, 1, 0, 0, Z, 0);
`endif
        // let the monitor drain the queue, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
